axi_chan_buf: RTL and testbench

- Generic, parametrised buffer for one AXI channel (AW, W, B, AR or R), generalising the fixed-width channel bundle to any payload width and depth.
- Inserted between a manager and a subordinate per channel to break valid/ready timing paths and absorb bursts.
- Tracks how many complete bursts (entries with the LAST bit set) are held.
- Optional packet mode forwards only whole bursts.

---
 rtl/axi_chan_buf.sv | 81 ++++++++
 tb/tb_axi_chan_buf.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_chan_buf.sv
// Parametrised single-channel AXI skid/burst buffer with complete-burst tracking.
// Define AXI_CHAN_BUF_PKT_MODE_EN to forward only whole bursts (packet mode).
module axi_chan_buf #(
   parameter int unsigned PWIDTH   = 64,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned HAS_LAST = 1,
   parameter int unsigned LAST_IDX = 0
) (
   input  logic                       i_aclk,
   input  logic                       i_rst,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [PWIDTH-1:0]          i_payload,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [PWIDTH-1:0]          o_payload,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic [$clog2(DEPTH+1)-1:0] o_bursts
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PWIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, bursts;
   logic              push, pop, in_last, out_last;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   if (HAS_LAST != 0) begin : g_last
      assign in_last  = i_payload[LAST_IDX];
      assign out_last = o_payload[LAST_IDX];
   end else begin : g_nolast
      assign in_last  = 1'b1;
      assign out_last = 1'b1;
   end

   // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
   assign o_ready = !i_rst && (count != CW'(DEPTH));

`ifdef AXI_CHAN_BUF_PKT_MODE_EN
   // The full term lets a burst longer than DEPTH drain as cut-through instead of deadlocking.
   assign o_valid = (bursts != '0) || (count == CW'(DEPTH));
`else
   assign o_valid = (count != '0);
`endif

   assign push      = i_valid && o_ready;
   assign pop       = o_valid && i_ready && !i_rst;
   assign o_payload = mem[rd_ptr];
   assign o_count   = count;
   assign o_bursts  = bursts;

   always_ff @(posedge i_aclk) begin
      if (push) begin
         mem[wr_ptr] <= i_payload;
      end
   end

   always_ff @(posedge i_aclk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         bursts <= '0;
      end else begin
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         count  <= count + CW'(push) - CW'(pop);
         bursts <= bursts + CW'(push && in_last) - CW'(pop && out_last);
      end
   end

endmodule

// File: tb/tb_axi_chan_buf.sv
// Directed, table-driven bench for axi_chan_buf across several depths.
// Packet-mode sequences run only when AXI_CHAN_BUF_PKT_MODE_EN is defined.
module tb_axi_chan_buf;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef AXI_CHAN_BUF_PKT_MODE_EN
   localparam bit PKT = 1'b1;
`else
   localparam bit PKT = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // DEPTH=4, LAST at bit 0
   logic       v4 = 0, r4 = 0, rdy4, ov4;
   logic [7:0] p4 = '0, op4;
   logic [2:0] c4, b4;
   // DEPTH=3, no LAST
   logic       v3 = 0, r3 = 0, rdy3, ov3;
   logic [7:0] p3 = '0, op3;
   logic [1:0] c3, b3;
   // DEPTH=2, LAST at bit 0
   logic       v2 = 0, r2 = 0, rdy2, ov2;
   logic [7:0] p2 = '0, op2;
   logic [1:0] c2, b2;
   // DEPTH=8, LAST at bit 0
   logic       v8 = 0, r8 = 0, rdy8, ov8;
   logic [7:0] p8 = '0, op8;
   logic [3:0] c8, b8;

   axi_chan_buf #(.PWIDTH(8), .DEPTH(4), .HAS_LAST(1), .LAST_IDX(0)) u4 (
      .i_aclk(clk), .i_rst(rst), .i_valid(v4), .o_ready(rdy4), .i_payload(p4),
      .o_valid(ov4), .i_ready(r4), .o_payload(op4), .o_count(c4), .o_bursts(b4));
   axi_chan_buf #(.PWIDTH(8), .DEPTH(3), .HAS_LAST(0), .LAST_IDX(0)) u3 (
      .i_aclk(clk), .i_rst(rst), .i_valid(v3), .o_ready(rdy3), .i_payload(p3),
      .o_valid(ov3), .i_ready(r3), .o_payload(op3), .o_count(c3), .o_bursts(b3));
   axi_chan_buf #(.PWIDTH(8), .DEPTH(2), .HAS_LAST(1), .LAST_IDX(0)) u2 (
      .i_aclk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy2), .i_payload(p2),
      .o_valid(ov2), .i_ready(r2), .o_payload(op2), .o_count(c2), .o_bursts(b2));
   axi_chan_buf #(.PWIDTH(8), .DEPTH(8), .HAS_LAST(1), .LAST_IDX(0)) u8 (
      .i_aclk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8), .i_payload(p8),
      .o_valid(ov8), .i_ready(r8), .o_payload(op8), .o_count(c8), .o_bursts(b8));

   typedef struct {
      bit v; bit r; int pl;
      int cnt; int bur; int vn; int vp; int rdy; int head;
   } vec_t;
   vec_t tbl [13];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      v4 = 0; r4 = 0; v3 = 0; r3 = 0; v2 = 0; r2 = 0; v8 = 0; r8 = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1, 0, 'h10, 1, 0, 1, 0, 1, 'h10};
      tbl[1]  = '{1, 0, 'h11, 2, 1, 1, 1, 1, 'h10};
      tbl[2]  = '{1, 0, 'h20, 3, 1, 1, 1, 1, 'h10};
      tbl[3]  = '{1, 0, 'h21, 4, 2, 1, 1, 0, 'h10};
      tbl[4]  = '{1, 1, 'h30, 3, 2, 1, 1, 1, 'h11};
      tbl[5]  = '{0, 1, 'h00, 2, 1, 1, 1, 1, 'h20};
      tbl[6]  = '{1, 1, 'h31, 2, 2, 1, 1, 1, 'h21};
      tbl[7]  = '{0, 1, 'h00, 1, 1, 1, 1, 1, 'h31};
      tbl[8]  = '{1, 1, 'h40, 1, 0, 1, 0, 1, 'h40};
      tbl[9]  = '{1, 0, 'h41, 2, 1, 1, 1, 1, 'h40};
      tbl[10] = '{0, 1, 'h00, 1, 1, 1, 1, 1, 'h41};
      tbl[11] = '{0, 1, 'h00, 0, 0, 0, 0, 1, 'h00};
      tbl[12] = '{0, 1, 'h00, 0, 0, 0, 0, 1, 'h00};

      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_count", 32'(c4), 0);
      chk("rst_bursts", 32'(b4), 0);
      chk("rst_valid", 32'(ov4), 0);
      chk("rst_ready", 32'(rdy4), 1);

      // Fill DEPTH=4 with downstream stalled, then reset mid-operation
      for (int i = 0; i < 4; i++) begin
         v4 = 1; r4 = 0; p4 = 8'(8'hA1 + i);
         tick();
      end
      v4 = 0;
      chk("fill_count", 32'(c4), 4);
      chk("fill_ready", 32'(rdy4), 0);
      chk("fill_head", 32'(op4), 'hA1);
      chk("fill_valid", 32'(ov4), 1);
      rst = 1'b1;
      #1;
      chk("ready_in_rst", 32'(rdy4), 0);
      tick();
      chk("after_rst_count", 32'(c4), 0);
      chk("after_rst_valid", 32'(ov4), 0);
      chk("after_rst_ready", 32'(rdy4), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(rdy4), 1);

      // Table: burst counting, full-with-pop, mixed push/pop on DEPTH=4
      for (int i = 0; i < 13; i++) begin
         v4 = tbl[i].v; r4 = tbl[i].r; p4 = 8'(tbl[i].pl);
         tick();
         chk($sformatf("tbl%0d_count", i), 32'(c4), tbl[i].cnt);
         chk($sformatf("tbl%0d_bursts", i), 32'(b4), tbl[i].bur);
         chk($sformatf("tbl%0d_valid", i), 32'(ov4), PKT ? tbl[i].vp : tbl[i].vn);
         chk($sformatf("tbl%0d_ready", i), 32'(rdy4), tbl[i].rdy);
         if (tbl[i].cnt != 0)
            chk($sformatf("tbl%0d_head", i), 32'(op4), tbl[i].head);
      end

      // Streaming through DEPTH=3: pointers wrap, count holds at 1
      pulse_reset();
      v3 = 1; r3 = 1;
      for (int k = 0; k < 20; k++) begin
         p3 = 8'(k);
         tick();
         chk($sformatf("stream%0d_count", k), 32'(c3), 1);
         chk($sformatf("stream%0d_head", k), 32'(op3), k);
         chk($sformatf("stream%0d_valid", k), 32'(ov3), 1);
      end
      v3 = 0;
      tick();
      chk("stream_drain_count", 32'(c3), 0);
      chk("stream_drain_valid", 32'(ov3), 0);

      // Full DEPTH=2 with simultaneous pop: pop happens, push refused
      pulse_reset();
      v2 = 1; r2 = 0; p2 = 8'h02;
      tick();
      p2 = 8'h04;
      tick();
      chk("full2_count", 32'(c2), 2);
      chk("full2_ready", 32'(rdy2), 0);
      v2 = 1; r2 = 1; p2 = 8'h06;
      tick();
      chk("fullpop_count", 32'(c2), 1);
      chk("fullpop_head", 32'(op2), 'h04);
      chk("fullpop_bursts", 32'(b2), 0);

`ifdef AXI_CHAN_BUF_PKT_MODE_EN
      // Packet mode, DEPTH=8: held until LAST arrives, then whole burst drains
      pulse_reset();
      v8 = 1; r8 = 1; p8 = 8'h10;
      tick();
      chk("pkt_b0_valid", 32'(ov8), 0);
      p8 = 8'h12;
      tick();
      chk("pkt_b1_valid", 32'(ov8), 0);
      chk("pkt_b1_count", 32'(c8), 2);
      p8 = 8'h15;
      tick();
      chk("pkt_last_valid", 32'(ov8), 1);
      chk("pkt_last_count", 32'(c8), 3);
      chk("pkt_last_head", 32'(op8), 'h10);
      v8 = 0;
      tick();
      chk("pkt_pop1_valid", 32'(ov8), 1);
      chk("pkt_pop1_head", 32'(op8), 'h12);
      tick();
      chk("pkt_pop2_valid", 32'(ov8), 1);
      chk("pkt_pop2_head", 32'(op8), 'h15);
      tick();
      chk("pkt_done_valid", 32'(ov8), 0);
      chk("pkt_done_count", 32'(c8), 0);

      // Packet overflow, DEPTH=2: full override releases beats without deadlock
      pulse_reset();
      v2 = 1; r2 = 0; p2 = 8'h20;
      tick();
      chk("ovf_one_valid", 32'(ov2), 0);
      p2 = 8'h22;
      tick();
      chk("ovf_full_valid", 32'(ov2), 1);
      chk("ovf_full_count", 32'(c2), 2);
      r2 = 1; p2 = 8'h25;
      tick();
      chk("ovf_pop_count", 32'(c2), 1);
      chk("ovf_pop_head", 32'(op2), 'h22);
      tick();
      chk("ovf_last_count", 32'(c2), 2);
      chk("ovf_last_bursts", 32'(b2), 1);
      chk("ovf_last_valid", 32'(ov2), 1);
      v2 = 0;
      tick();
      chk("ovf_drain_head", 32'(op2), 'h25);
      chk("ovf_drain_count", 32'(c2), 1);
      tick();
      chk("ovf_empty_count", 32'(c2), 0);
      chk("ovf_empty_valid", 32'(ov2), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
